ram_2port_pipe_param: RTL and testbench
=======================================

# ram_2port_pipe_param

Parametrised simple dual-port RAM (one write port, one read port, one clock) with a registered read address, a registered array read and a configurable number of output register stages. Adds read-enable/read-valid tracking, a selectable same-address collision policy, optional per-word parity with error flagging, and synchronous reset of all control and output state. It sits as the generic storage primitive beneath FIFOs, line buffers and lookup tables, and maps onto block RAM.

## Interface

- DW, 18: data width in bits (1..64)
- AW, 10: address width; depth is 2**AW words
- OUT_REGS, 1: extra output register stages after the array read register (0..3)
- WR_FIRST, 0: collision policy; 0 = read-first (old data), 1 = write-first (new data)

- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr  input  1  write enable
- waddr  input  AW  write address
- din  input  DW  write data
- par_inject  input  1  with wr, store inverted parity bit (test hook); ignored without parity
- rd_en  input  1  read request
- raddr  input  AW  read address, sampled when rd_en=1
- dout  output  DW  read data
- rd_valid  output  1  dout holds data for a completed request this cycle
- par_err  output  1  parity mismatch on the word in dout; qualified by rd_valid

## Operation

- Write: on an edge with wr=1 and rst=0, mem[waddr] <= din. No write handshake; one write per cycle.
- Read pipeline: S1 registers {rd_en, raddr}. S2 registers the array word at the S1 address plus its valid bit. Then OUT_REGS stages O1..On copy data and valid forward.
- Valid bits shift every cycle. A data register loads only when its incoming valid is 1; otherwise it holds. dout therefore keeps the last read word between reads.
- Back-to-back reads are accepted every cycle. There is no stall and no backpressure.
- Collision: wr=1 and waddr equals the S1 address in the cycle S2 loads.
  - WR_FIRST=1: S2 loads din.
  - WR_FIRST=0: S2 loads the prior contents.
  - The array is written either way.
- A collision with a request still in S1's input, or already past S2, has no special handling. Stages past S2 keep the data they captured.
- Reset: rst=1 clears all valid bits, S1 address, all data registers, dout, rd_valid and par_err to 0 at the next edge.
  - In-flight reads are dropped; rd_valid=0 on the cycle after the reset edge.
  - Writes and rd_en are ignored while rst=1.
  - Array contents are not cleared; they are undefined until written.
- Addresses wrap naturally modulo 2**AW. No out-of-range case exists.

## Timing

- Request presented in cycle T (rd_en=1): rd_valid=1 with the data in dout during cycle T+2+OUT_REGS. With the default OUT_REGS=1, latency is 3 cycles.
- A write at edge E is visible to a request whose S1 address reaches S2 after E. With WR_FIRST=1, it is also visible at exactly edge E.
- par_err is produced and aligned on the same stage and cycle as rd_valid.
- rd_valid pulses once per request; N consecutive requests give N consecutive valid cycles.

## Configuration

- RAM_2PORT_PARITY_EN defined:
  - The array is DW+1 bits wide. Stored bit DW is the XOR of din, inverted when par_inject=1.
  - S2 recomputes the parity and registers the mismatch. The mismatch travels with the data; par_err=1 only with rd_valid=1.
  - Write-first bypass carries the din parity with the par_inject inversion applied.
- Macro undefined:
  - The array is DW bits wide.
  - par_inject is ignored.
  - par_err is constantly 0.

## Test plan

- Reset then single read: write mem[5]=18'h2A5A5; one cycle later rd_en with raddr=5 at T → rd_valid=1 and dout=18'h2A5A5 at T+3 only; rd_valid=0 otherwise; dout holds 18'h2A5A5 afterwards.
- Streaming: write addresses 0..15 with data 100+i, then 16 consecutive reads of 0..15 → 16 consecutive rd_valid cycles, in order. Repeat with OUT_REGS=0 and OUT_REGS=3, checking latency of 2 and 5.
- Collision: mem[9]=18'h00001, then wr to 9 with din=18'h3FFFF in the cycle S1 holds address 9 → dout=18'h3FFFF when WR_FIRST=1 and 18'h00001 when WR_FIRST=0. A following read of 9 returns 18'h3FFFF in both cases.
- Reset mid-flight: issue reads at T and T+1, assert rst at T+2 for one cycle → no rd_valid at T+3 or T+4; dout=0 and par_err=0 after the reset edge; mem contents are retained and a later read of the same address returns the earlier data.
- Parity (macro defined): write 18'h00003 with par_inject=1, then read → par_err=1 with rd_valid. A normal write and read of the same address → par_err=0. Macro undefined → par_err is always 0.
- Wrap: AW=4, write addr 15 and addr 0, then read 15 then 0 → correct data in order, with no aliasing.

Source files
------------

// File: rtl/ram_2port_pipe_param.sv
// ram_2port_pipe_param: 1W/1R RAM, registered read, OUT_REGS output stages, optional parity via RAM_2PORT_PARITY_EN
module ram_2port_pipe_param #(
  parameter int DW = 18,
  parameter int AW = 10,
  parameter int OUT_REGS = 1,
  parameter int WR_FIRST = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic          par_inject,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] dout,
  output logic          rd_valid,
  output logic          par_err
);
`ifdef RAM_2PORT_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif
  logic [MW-1:0] mem [2**AW];
  logic [MW-1:0] wword, rword;
  logic          rerr;
  logic          s1_v;
  logic [AW-1:0] s1_a;
  logic          v [OUT_REGS+1];
  logic          e [OUT_REGS+1];
  logic [DW-1:0] d [OUT_REGS+1];
`ifdef RAM_2PORT_PARITY_EN
  assign wword = {^din ^ par_inject, din};
  assign rerr = ^rword;
`else
  logic unused_par;
  assign wword = din;
  assign rerr = 1'b0;
  assign unused_par = par_inject;
`endif
  assign rword = (WR_FIRST != 0 && wr && waddr == s1_a) ? wword : mem[s1_a];
  // array write; contents survive reset
  always_ff @(posedge clk)
    if (wr && !rst) mem[waddr] <= wword;
  // S1 captures the request, S2 captures the array word and its parity check
  always_ff @(posedge clk)
    if (rst) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      v[0] <= 1'b0;
      d[0] <= '0;
      e[0] <= 1'b0;
    end else begin
      s1_v <= rd_en;
      if (rd_en) s1_a <= raddr;
      v[0] <= s1_v;
      if (s1_v) begin
        d[0] <= rword[DW-1:0];
        e[0] <= rerr;
      end
    end
  for (genvar k = 1; k <= OUT_REGS; k++) begin : g_out
    // output stage: valid shifts every cycle, data and error load only with valid
    always_ff @(posedge clk)
      if (rst) begin
        v[k] <= 1'b0;
        d[k] <= '0;
        e[k] <= 1'b0;
      end else begin
        v[k] <= v[k-1];
        if (v[k-1]) begin
          d[k] <= d[k-1];
          e[k] <= e[k-1];
        end
      end
  end
  assign dout = d[OUT_REGS];
  assign rd_valid = v[OUT_REGS];
  assign par_err = v[OUT_REGS] & e[OUT_REGS];
endmodule

// File: tb/tb_ram_2port_pipe_param.sv
// tb_ram_2port_pipe_param: directed table, hand sequences and random traffic against a schedule-based model
module tb_ram_2port_pipe_param;
  localparam int NI = 4;
  logic clk, rst, wr, par_inject, rd_en;
  logic [9:0] waddr, raddr;
  logic [17:0] din;
  logic [17:0] q [NI];
  logic qv [NI], qe [NI];
  int ors [NI] = '{1, 0, 3, 1};
  int wfs [NI] = '{0, 1, 1, 0};
  int msk [NI] = '{1023, 1023, 1023, 15};
  int checks = 0, errors = 0;

  ram_2port_pipe_param u0 (.clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .din(din), .par_inject(par_inject),
    .rd_en(rd_en), .raddr(raddr), .dout(q[0]), .rd_valid(qv[0]), .par_err(qe[0]));
  ram_2port_pipe_param #(.OUT_REGS(0), .WR_FIRST(1)) u1 (.clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .din(din),
    .par_inject(par_inject), .rd_en(rd_en), .raddr(raddr), .dout(q[1]), .rd_valid(qv[1]), .par_err(qe[1]));
  ram_2port_pipe_param #(.OUT_REGS(3), .WR_FIRST(1)) u2 (.clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .din(din),
    .par_inject(par_inject), .rd_en(rd_en), .raddr(raddr), .dout(q[2]), .rd_valid(qv[2]), .par_err(qe[2]));
  ram_2port_pipe_param #(.AW(4)) u3 (.clk(clk), .rst(rst), .wr(wr), .waddr(waddr[3:0]), .din(din),
    .par_inject(par_inject), .rd_en(rd_en), .raddr(raddr[3:0]), .dout(q[3]), .rd_valid(qv[3]), .par_err(qe[3]));

  initial clk = 0;
  always #5 clk = ~clk;

  // model: memory image plus a ring of results scheduled by the edge they appear at
  logic [17:0] mm [NI][1024];
  bit mp [NI][1024];
  bit rq_v [NI];
  int rq_a [NI];
  bit sv [NI][8];
  bit sp [NI][8];
  logic [17:0] sd [NI][8];
  logic [17:0] xd [NI];
  bit xv [NI], xp [NI];
  int e = 0;

  task automatic model();
    for (int m = 0; m < NI; m++) begin
      if (rst) begin
        for (int s = 0; s < 8; s++) sv[m][s] = 0;
        xv[m] = 0; xd[m] = 0; xp[m] = 0; rq_v[m] = 0;
      end else begin
        if (rq_v[m]) begin
          int sl = (e + ors[m]) % 8;
          bit hit = wfs[m] != 0 && wr && ((int'(waddr) & msk[m]) == rq_a[m]);
          sv[m][sl] = 1;
          sd[m][sl] = hit ? din : mm[m][rq_a[m]];
          sp[m][sl] = hit ? par_inject : mp[m][rq_a[m]];
        end
        xv[m] = sv[m][e % 8];
        if (xv[m]) begin
          xd[m] = sd[m][e % 8];
          xp[m] = sp[m][e % 8];
        end
        sv[m][e % 8] = 0;
        if (wr) begin
          mm[m][int'(waddr) & msk[m]] = din;
          mp[m][int'(waddr) & msk[m]] = par_inject;
        end
        rq_v[m] = rd_en;
        if (rd_en) rq_a[m] = int'(raddr) & msk[m];
      end
    end
    e++;
  endtask

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d at t=%0t: got %h expected %h", name, m, $time, act, exp);
    end
  endtask

  function automatic bit exp_perr(input int m);
`ifdef RAM_2PORT_PARITY_EN
    return xv[m] && xp[m];
`else
    return 1'b0 && m >= 0;
`endif
  endfunction

  task automatic step(input bit r, input bit w, input int wa, input logic [17:0] d, input bit inj, input bit re, input int ra);
    rst = r; wr = w; waddr = wa[9:0]; din = d; par_inject = inj; rd_en = re; raddr = ra[9:0];
    @(posedge clk);
    model();
    #1;
    for (int m = 0; m < NI; m++) begin
      chk("dout", m, 32'(q[m]), 32'(xd[m]));
      chk("rd_valid", m, 32'(qv[m]), 32'(xv[m]));
      chk("par_err", m, 32'(qe[m]), 32'(exp_perr(m)));
    end
  endtask

  typedef struct {
    bit r, w;
    int wa;
    logic [17:0] d;
    bit re;
    int ra;
    bit ev;
    logic [17:0] ed;
  } vec_t;
  vec_t tv [21];

  initial begin
    int first [NI], cnt [NI];
    tv[0]  = '{1, 0, 0, 18'h0, 0, 0, 0, 18'h0};
    tv[1]  = '{0, 1, 5, 18'h2A5A5, 0, 0, 0, 18'h0};
    tv[2]  = '{0, 0, 0, 18'h0, 0, 0, 0, 18'h0};
    tv[3]  = '{0, 0, 0, 18'h0, 1, 5, 0, 18'h0};
    tv[4]  = '{0, 0, 0, 18'h0, 0, 0, 0, 18'h0};
    tv[5]  = '{0, 0, 0, 18'h0, 0, 0, 1, 18'h2A5A5};
    tv[6]  = '{0, 0, 0, 18'h0, 0, 0, 0, 18'h2A5A5};
    tv[7]  = '{0, 1, 9, 18'h00001, 0, 0, 0, 18'h2A5A5};
    tv[8]  = '{0, 0, 0, 18'h0, 1, 9, 0, 18'h2A5A5};
    tv[9]  = '{0, 1, 9, 18'h3FFFF, 0, 0, 0, 18'h2A5A5};
    tv[10] = '{0, 0, 0, 18'h0, 1, 9, 1, 18'h00001};
    tv[11] = '{0, 0, 0, 18'h0, 0, 0, 0, 18'h00001};
    tv[12] = '{0, 0, 0, 18'h0, 0, 0, 1, 18'h3FFFF};
    tv[13] = '{0, 0, 0, 18'h0, 1, 9, 0, 18'h3FFFF};
    tv[14] = '{0, 0, 0, 18'h0, 1, 5, 0, 18'h3FFFF};
    tv[15] = '{1, 0, 0, 18'h0, 0, 0, 0, 18'h0};
    tv[16] = '{0, 0, 0, 18'h0, 0, 0, 0, 18'h0};
    tv[17] = '{0, 0, 0, 18'h0, 1, 5, 0, 18'h0};
    tv[18] = '{0, 0, 0, 18'h0, 0, 0, 0, 18'h0};
    tv[19] = '{0, 0, 0, 18'h0, 0, 0, 1, 18'h2A5A5};
    tv[20] = '{0, 0, 0, 18'h0, 0, 0, 0, 18'h2A5A5};
    for (int i = 0; i < 21; i++) begin
      step(tv[i].r, tv[i].w, tv[i].wa, tv[i].d, 0, tv[i].re, tv[i].ra);
      chk($sformatf("tbl_valid[%0d]", i), 0, 32'(qv[0]), 32'(tv[i].ev));
      chk($sformatf("tbl_dout[%0d]", i), 0, 32'(q[0]), 32'(tv[i].ed));
    end
    // streaming: 16 writes then 16 back-to-back reads, latency and order per instance
    for (int i = 0; i < 16; i++) step(0, 1, i, 18'(100 + i), 0, 0, 0);
    for (int m = 0; m < NI; m++) begin first[m] = -1; cnt[m] = 0; end
    for (int k = 0; k < 23; k++) begin
      step(0, 0, 0, 0, 0, k < 16, k);
      for (int m = 0; m < NI; m++)
        if (qv[m]) begin
          if (first[m] < 0) first[m] = k;
          chk("stream_order", m, 32'(q[m]), 32'(100 + cnt[m]));
          cnt[m]++;
        end
    end
    for (int m = 0; m < NI; m++) begin
      chk("stream_latency", m, 32'(first[m]), 32'(1 + ors[m]));
      chk("stream_count", m, 32'(cnt[m]), 32'd16);
    end
    // wrap on the 16-word instance
    step(0, 1, 15, 18'h15151, 0, 0, 0);
    step(0, 1, 0, 18'h00A0A, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 15);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap15", 3, 32'(q[3]), 32'h15151);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("wrap0", 3, 32'(q[3]), 32'h00A0A);
    // parity inject, then a clean rewrite of the same word
    step(0, 1, 3, 18'h00003, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
`ifdef RAM_2PORT_PARITY_EN
    chk("par_inject", 0, 32'(qe[0]), 32'd1);
`else
    chk("par_inject", 0, 32'(qe[0]), 32'd0);
`endif
    chk("par_valid", 0, 32'(qv[0]), 32'd1);
    step(0, 1, 3, 18'h00003, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("par_clean", 0, 32'(qe[0]), 32'd0);
    // random traffic over a prefilled window of 32 words
    for (int i = 0; i < 32; i++) step(0, 1, i, 18'($urandom), 0, 0, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(49) == 0, 1'($urandom), $urandom_range(31), 18'($urandom),
           $urandom_range(7) == 0, 1'($urandom), $urandom_range(31));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
